// File: rtl/hazard_ctrl.sv
// hazard_ctrl
// Stall/flush controller for the 5-stage pipeline. Each cycle it chooses the
// latch enables and flushes for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB
// registers. It decides from the cache hit signals, load-use hazards, taken
// redirects and HALT. Operand hazards are not handled here; forwarding does that.
//
// Ports
//   CLK, nRST        : clock (rising edge) and asynchronous active-low reset
//   ihit, dhit       : icache / dcache completed this cycle
//   ifid_instr       : IF/ID instruction (rs = [25:21], rt = [20:16])
//   idex_memread/rt  : ID/EX load and its destination register
//   exmem_dmemren/wen: EX/MEM data read / write
//   exmem_redirect   : EX/MEM taken branch or jump
//   exmem_halt       : EX/MEM holds HALT
//   pc_en, *_en      : latch enables; *_flush loads zero (en is also 1 on flush)
//   halted           : sticky halt, cleared only by reset
//   stall_count      : saturating count of non-HALT cycles with pc_en = 0
//   redirect_count   : saturating count of accepted redirects
module hazard_ctrl #(
    parameter int STALL_W = 16,
    parameter int REDIR_W = 16
) (
    input  logic               CLK,
    input  logic               nRST,
    input  logic               ihit,
    input  logic               dhit,
    input  logic [31:0]        ifid_instr,
    input  logic               idex_memread,
    input  logic [4:0]         idex_rt,
    input  logic               exmem_dmemren,
    input  logic               exmem_dmemwen,
    input  logic               exmem_redirect,
    input  logic               exmem_halt,
    output logic               pc_en,
    output logic               ifid_en,
    output logic               ifid_flush,
    output logic               idex_en,
    output logic               idex_flush,
    output logic               exmem_en,
    output logic               memwb_en,
    output logic               halted,
    output logic [STALL_W-1:0] stall_count,
    output logic [REDIR_W-1:0] redirect_count
);

    typedef enum logic [1:0] {RUN, DWAIT, HALT} state_t;

    state_t state_reg, state_next;
    logic [STALL_W-1:0] stall_count_reg;
    logic [REDIR_W-1:0] redirect_count_reg;

    logic memop, dmem_ok, lu;
    logic resolve, ihit_eff, redirect_taken;
    logic pc_en_raw, ifid_en_raw, ifid_flush_raw, idex_en_raw, idex_flush_raw;
    logic exmem_en_raw, memwb_en_raw;

    // Only the rs/rt fields take part in the load-use compare.
    logic unused_instr_bits;
    assign unused_instr_bits = ^{ifid_instr[31:26], ifid_instr[15:0]};

    assign memop   = exmem_dmemren | exmem_dmemwen;
    assign dmem_ok = ~memop | dhit;
    assign lu      = idex_memread && (idex_rt != 5'd0) &&
                     ((idex_rt == ifid_instr[25:21]) || (idex_rt == ifid_instr[20:16]));

    always_comb begin
        state_next     = state_reg;
        resolve        = 1'b0;
        ihit_eff       = ihit;
        redirect_taken = 1'b0;
        pc_en_raw      = 1'b0;
        ifid_en_raw    = 1'b0;
        ifid_flush_raw = 1'b0;
        idex_en_raw    = 1'b0;
        idex_flush_raw = 1'b0;
        exmem_en_raw   = 1'b0;
        memwb_en_raw   = 1'b0;

        case (state_reg)
            RUN: begin
                if (exmem_halt && dmem_ok) begin
                    // Let the HALT retire into MEM/WB, freeze everything else.
                    memwb_en_raw = 1'b1;
                    state_next   = HALT;
                end else if (memop && !dhit) begin
                    state_next = DWAIT;
                end else begin
                    resolve = 1'b1;
                end
            end
            DWAIT: begin
                if (dhit) begin
                    // The fetch that was frozen behind the data miss is treated
                    // as missed: refetch instead of trusting a stale ihit.
                    resolve    = 1'b1;
                    ihit_eff   = 1'b0;
                    state_next = RUN;
                end
            end
            default: ;
        endcase

        if (resolve) begin
            if (exmem_redirect) begin
                redirect_taken = 1'b1;
                pc_en_raw      = 1'b1;
                ifid_en_raw    = 1'b1;
                ifid_flush_raw = 1'b1;
                idex_en_raw    = 1'b1;
                idex_flush_raw = 1'b1;
                exmem_en_raw   = 1'b1;
                memwb_en_raw   = 1'b1;
            end else if (lu) begin
                // Hold PC and IF/ID, inject a bubble into ID/EX.
                idex_en_raw    = 1'b1;
                idex_flush_raw = 1'b1;
                exmem_en_raw   = 1'b1;
                memwb_en_raw   = 1'b1;
            end else if (!ihit_eff) begin
                ifid_en_raw    = 1'b1;
                ifid_flush_raw = 1'b1;
                idex_en_raw    = 1'b1;
                exmem_en_raw   = 1'b1;
                memwb_en_raw   = 1'b1;
            end else begin
                pc_en_raw    = 1'b1;
                ifid_en_raw  = 1'b1;
                idex_en_raw  = 1'b1;
                exmem_en_raw = 1'b1;
                memwb_en_raw = 1'b1;
            end
        end
    end

    // All controls drop as soon as reset asserts, without waiting for a clock.
    assign pc_en      = nRST & pc_en_raw;
    assign ifid_en    = nRST & ifid_en_raw;
    assign ifid_flush = nRST & ifid_flush_raw;
    assign idex_en    = nRST & idex_en_raw;
    assign idex_flush = nRST & idex_flush_raw;
    assign exmem_en   = nRST & exmem_en_raw;
    assign memwb_en   = nRST & memwb_en_raw;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_reg          <= RUN;
            stall_count_reg    <= '0;
            redirect_count_reg <= '0;
        end else begin
            state_reg <= state_next;
            if ((state_reg != HALT) && !pc_en_raw && (stall_count_reg != {STALL_W{1'b1}}))
                stall_count_reg <= stall_count_reg + 1'b1;
            if (redirect_taken && (redirect_count_reg != {REDIR_W{1'b1}}))
                redirect_count_reg <= redirect_count_reg + 1'b1;
        end
    end

    assign halted         = (state_reg == HALT);
    assign stall_count    = stall_count_reg;
    assign redirect_count = redirect_count_reg;

endmodule
